// File: rtl/aes_dec_ark_stage_pkg.sv
// Shared types and constants for the AES-256 decryption AddRoundKey stage.
// Imported by the stage top, its interface and the column helper.
package aes_dec_pkg;

    localparam int NR = 14;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        HOLD = 2'd2
    } ark_fsm_t;

    // Column 0 sits in the top 32 bits, so column c starts at bit 96 - 32*c.
    function automatic int col_lsb(input logic [1:0] c);
        return (3 - int'(c)) * 32;
    endfunction

endpackage

// File: rtl/aes_dec_ark_stage_if.sv
// Handshake bundle of the AddRoundKey stage: upstream state/key/round with
// valid/ready, and the downstream processed state with valid/ready.
interface aes_dec_ark_stage_if;
    import aes_dec_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_state;
    aes_state_t round_key;
    logic [3:0] round_idx;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;

    // The stage itself.
    modport slave (
        input  in_valid,
        input  in_state,
        input  round_key,
        input  round_idx,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

    // Whoever feeds the stage and consumes its result.
    modport master (
        output in_valid,
        output in_state,
        output round_key,
        output round_idx,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

endinterface

// File: rtl/aes_dec_ark_stage_mix.sv
// MixColumnHelper: combinational InvMixColumns of one 32-bit column.
// Byte 0 of the column is the most significant byte.
module MixColumnHelper
    import aes_dec_pkg::*;
(
    input  aes_col_t col_in,
    output aes_col_t col_out
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    // Inverse MixColumns matrix rows {0e 0b 0d 09} rotated per output byte.
    always_comb begin
        col_out[31:24] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
        col_out[23:16] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
        col_out[15:8]  = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
        col_out[7:0]   = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end

endmodule

// File: rtl/aes_dec_ark_stage.sv
// Registered AddRoundKey stage of the AES-256 decryption datapath.
// XORs the round key into the incoming state, then applies InvMixColumns on
// inner rounds before presenting the result downstream.
// Build option: AES_DEC_INVMIX_PARALLEL_EN mixes all four columns in a single
// MIX cycle with four helpers; default is one helper, one column per cycle.
//
// state | meaning
// IDLE  | ready for a new block
// MIX   | InvMixColumns in progress (column col, or all at once)
// HOLD  | result valid, waiting for downstream ready
module aes_dec_ark_stage #(
    parameter int NR = aes_dec_pkg::NR
) (
    input logic              clk,
    input logic              rst,
    aes_dec_ark_stage_if.slave bus
);
    import aes_dec_pkg::*;

    ark_fsm_t   fsm;
    logic [1:0] col;
    aes_state_t st;
    logic       out_valid_q;
    logic       mix_round;

    // Rounds 0 and NR only add the key; anything above NR is treated the same.
    assign mix_round = (bus.round_idx != 4'd0) && (bus.round_idx < 4'(NR));

    assign bus.in_ready  = (fsm == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = st;

`ifdef AES_DEC_INVMIX_PARALLEL_EN
    aes_state_t mixed;

    for (genvar g = 0; g < 4; g++) begin : g_mix
        MixColumnHelper u_mix (
            .col_in  (st[col_lsb(2'(g)) +: 32]),
            .col_out (mixed[col_lsb(2'(g)) +: 32])
        );
    end
`else
    aes_col_t mix_in;
    aes_col_t mix_out;

    assign mix_in = st[col_lsb(col) +: 32];

    MixColumnHelper u_mix (
        .col_in  (mix_in),
        .col_out (mix_out)
    );
`endif

    // Stage FSM: accept, mix, hold result until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            col         <= 2'd0;
            st          <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        st  <= bus.in_state ^ bus.round_key;
                        col <= 2'd0;
                        if (mix_round) begin
                            fsm <= MIX;
                        end else begin
                            fsm         <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MIX: begin
`ifdef AES_DEC_INVMIX_PARALLEL_EN
                    st          <= mixed;
                    fsm         <= HOLD;
                    out_valid_q <= 1'b1;
`else
                    st[col_lsb(col) +: 32] <= mix_out;
                    col                    <= col + 2'd1;
                    if (col == 2'd3) begin
                        fsm         <= HOLD;
                        out_valid_q <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        fsm         <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    fsm         <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_ark_stage.sv
// Self-checking bench for aes_dec_ark_stage (default or parallel build).
module tb_aes_dec_ark_stage;

    logic clk;
    logic rst;

    aes_dec_ark_stage_if bus ();

    aes_dec_ark_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef AES_DEC_INVMIX_PARALLEL_EN
    localparam int MIX_LAT = 2;
`else
    localparam int MIX_LAT = 5;
`endif
    localparam int BYP_LAT = 1;
    localparam int WAIT_MAX = 40;

    localparam logic [127:0] MIX_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] MIX_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BYP_KEY = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] BYP_OUT = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

    int checks   = 0;
    int failures = 0;

    logic [127:0] exp_q[$];
    int           lat_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference InvMixColumns built from a generic GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        coef[0] = 8'h0e;
        coef[1] = 8'h0b;
        coef[2] = 8'h0d;
        coef[3] = 8'h09;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(coef[(k - row) & 3], s[127 - 32*c - 8*k -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Wait for out_valid (bounded), then compare latency and popped expectation.
    task automatic expect_output(input string tag);
        int           lat;
        int           exp_lat;
        logic [127:0] exp;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < WAIT_MAX);
        if (exp_q.size() > 0) begin
            exp     = exp_q.pop_front();
            exp_lat = lat_q.pop_front();
        end else begin
            exp     = 'x;
            exp_lat = -1;
        end
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check({tag, "_state"}, bus.out_state, exp);
    endtask

    // One full block with out_ready high.
    task automatic send(input string tag, input logic [127:0] s, input logic [127:0] k,
                        input logic [3:0] idx, input logic [127:0] exp, input int exp_lat);
        @(negedge clk);
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        bus.in_valid  = 1'b1;
        bus.in_state  = s;
        bus.round_key = k;
        bus.round_idx = idx;
        exp_q.push_back(exp);
        lat_q.push_back(exp_lat);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        expect_output(tag);
    endtask

    initial begin
        logic [127:0] key;
        logic [127:0] rs;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.round_key = '0;
        bus.round_idx = 4'd0;
        bus.out_ready = 1'b1;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_out_state", bus.out_state, 128'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

        // Mixed round, zero key.
        send("mix_zero_key", MIX_IN, 128'(0), 4'd5, MIX_OUT, MIX_LAT);

        // Bypass rounds 0 and NR.
        send("byp_r0", BYP_IN, BYP_KEY, 4'd0, BYP_OUT, BYP_LAT);
        send("byp_r14", BYP_IN, BYP_KEY, 4'd14, BYP_OUT, BYP_LAT);

        // Key XOR plus mix on round 1.
        key = {$urandom, $urandom, $urandom, $urandom};
        send("mix_key_r1", MIX_IN ^ key, key, 4'd1, MIX_OUT, MIX_LAT);

        // Highest mixed round with a random state against the reference model.
        key = {$urandom, $urandom, $urandom, $urandom};
        rs  = {$urandom, $urandom, $urandom, $urandom};
        send("mix_rand_r13", rs, key, 4'd13, inv_mix(rs ^ key), MIX_LAT);

        // Out-of-range round is XOR only.
        send("byp_r15", BYP_IN, BYP_KEY, 4'd15, BYP_OUT, BYP_LAT);

        // Backpressure: hold result for 10 cycles with a second block waiting.
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_state  = BYP_IN;
        bus.round_key = BYP_KEY;
        bus.round_idx = 4'd0;
        exp_q.push_back(BYP_OUT);
        lat_q.push_back(BYP_LAT);
        @(posedge clk);
        #1;
        bus.in_state  = MIX_IN;
        bus.round_key = 128'(0);
        bus.round_idx = 4'd14;
        expect_output("bp_first");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stable_state", bus.out_state, BYP_OUT);
            check("bp_in_ready_low", 128'(bus.in_ready), 128'(0));
            check("bp_valid_held", 128'(bus.out_valid), 128'(1));
        end
        bus.out_ready = 1'b1;
        exp_q.push_back(MIX_IN);
        lat_q.push_back(BYP_LAT);
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 128'(bus.in_ready), 128'(1));
        check("bp_release_out_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        expect_output("bp_second");

        // Reset on the second MIX cycle drops the block.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_state  = MIX_IN;
        bus.round_key = 128'(0);
        bus.round_idx = 4'd7;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_out_state", bus.out_state, 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        send("after_abort", MIX_IN, 128'(0), 4'd2, MIX_OUT, MIX_LAT);

        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
